// File: rtl/m8_32_if.sv
// ---------------------------------------------------------------------------
// m8_32_if : byte-in / word-out bundle for the m8_32 byte-to-word gatherer.
//
// Signals:
//   data_in     [7:0]   received byte
//   valid_in            data_in is valid this cycle
//   data_8_32   [31:0]  assembled word, first byte in [31:24]
//   valid_8_32          one-cycle strobe: data_8_32 holds a new word
//   err_partial         one-cycle strobe: word aborted with 1-3 bytes held
//   word_cnt    [15:0]  complete words emitted since reset (wraps)
//
// Modports:
//   master : byte source / word sink (drives data_in, valid_in)
//   slave  : the gatherer itself (drives the word-side outputs)
// ---------------------------------------------------------------------------
interface m8_32_if;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_8_32;
    logic        valid_8_32;
    logic        err_partial;
    logic [15:0] word_cnt;

    modport master (
        output data_in, valid_in,
        input  data_8_32, valid_8_32, err_partial, word_cnt
    );

    modport slave (
        input  data_in, valid_in,
        output data_8_32, valid_8_32, err_partial, word_cnt
    );
endinterface

// File: rtl/m8_32.sv
// ---------------------------------------------------------------------------
// m8_32 : byte-to-word gatherer for the PCIe PHY receive path.
//
// Packs four consecutive valid bytes MSB-first into a 32-bit word and strobes
// valid_8_32 for one cycle when the word completes. Any cycle with valid_in
// low restarts assembly at lane 0; if bytes were pending, err_partial pulses.
//
// Ports:
//   clk_4f  byte-rate clock, all logic on posedge
//   reset   asynchronous, active-low reset
//   bus     m8_32_if.slave (data_in, valid_in, data_8_32, valid_8_32,
//           err_partial, word_cnt)
//
// Configuration:
//   M8_32_ALIGN_COM_EN  when defined, a COM_SYMBOL byte (K28.5 comma) seen in
//                       lanes 1..3 discards the partial word, pulses
//                       err_partial and restarts the word with the comma in
//                       [31:24]. The COM_SYMBOL parameter exists only then.
// ---------------------------------------------------------------------------
module m8_32
`ifdef M8_32_ALIGN_COM_EN
#(
    parameter logic [7:0] COM_SYMBOL = 8'hBC
)
`endif
(
    input  logic    clk_4f,
    input  logic    reset,
    m8_32_if.slave  bus
);

    typedef enum logic [1:0] {
        LANE0 = 2'd0,   // expecting [31:24]
        LANE1 = 2'd1,   // expecting [23:16]
        LANE2 = 2'd2,   // expecting [15:8]
        LANE3 = 2'd3    // expecting [7:0], completes the word
    } lane_e;

    lane_e       lane_q, lane_d;
    // Only the three leading bytes are ever held; the last byte goes straight
    // into the output word on the completing edge.
    logic [31:8] acc_q, acc_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    // State register.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            // NOTE: acc is a plain register, not a memory, so it is reset
            // along with everything else; mid-word bytes vanish silently.
            lane_q  <= LANE0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        lane_d  = lane_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (bus.valid_in) begin
`ifdef M8_32_ALIGN_COM_EN
            if (bus.data_in == COM_SYMBOL && lane_q != LANE0) begin
                // Comma mid-word: realign so the comma leads a fresh word.
                acc_d  = {COM_SYMBOL, 16'h0000};
                lane_d = LANE1;
                err_d  = 1'b1;
            end else
`endif
            begin
                unique case (lane_q)
                    LANE0: begin
                        acc_d[31:24] = bus.data_in;
                        lane_d       = LANE1;
                    end
                    LANE1: begin
                        acc_d[23:16] = bus.data_in;
                        lane_d       = LANE2;
                    end
                    LANE2: begin
                        acc_d[15:8] = bus.data_in;
                        lane_d      = LANE3;
                    end
                    LANE3: begin
                        data_d  = {acc_q[31:8], bus.data_in};
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 16'd1;   // wraps FFFF -> 0 silently
                        lane_d  = LANE0;
                    end
                    default: lane_d = LANE0;
                endcase
            end
        end else begin
            // Gap: restart at lane 0, flag only if bytes were pending.
            lane_d = LANE0;
            acc_d  = '0;
            err_d  = (lane_q != LANE0);
        end
    end

    assign bus.data_8_32   = data_q;
    assign bus.valid_8_32  = valid_q;
    assign bus.err_partial = err_q;
    assign bus.word_cnt    = cnt_q;

endmodule

// File: tb/tb_m8_32.sv
// ---------------------------------------------------------------------------
// tb_m8_32 : directed bench for m8_32. A small byte-lane model pushes each
// expected word into a queue when its fourth byte is driven; the word is
// popped and compared when the DUT strobes valid_8_32. Strobe, error, held
// data and word count are compared after every clock edge.
// ---------------------------------------------------------------------------
module tb_m8_32;

    logic clk_4f = 1'b0;
    logic reset  = 1'b0;

    always #5 clk_4f = ~clk_4f;

    m8_32_if bus ();

    m8_32 dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] exp_q[$];
    logic [7:0]  m_bytes [4];
    int          m_lane   = 0;
    logic [15:0] m_cnt    = '0;
    logic [31:0] last_word = '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one byte cycle, advance the model, then compare after the edge.
    task automatic step(input logic [7:0] d, input logic v);
        logic exp_strobe;
        logic exp_err;
        logic [31:0] word;
        exp_strobe = 1'b0;
        exp_err    = 1'b0;
        @(negedge clk_4f);
        bus.data_in  = d;
        bus.valid_in = v;
        if (v) begin
`ifdef M8_32_ALIGN_COM_EN
            if (d == 8'hBC && m_lane != 0) begin
                exp_err    = 1'b1;
                m_bytes[0] = d;
                m_lane     = 1;
            end else
`endif
            begin
                m_bytes[m_lane] = d;
                if (m_lane == 3) begin
                    exp_q.push_back({m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]});
                    m_cnt      = m_cnt + 16'd1;
                    exp_strobe = 1'b1;
                    m_lane     = 0;
                end else begin
                    m_lane++;
                end
            end
        end else begin
            exp_err = (m_lane != 0);
            m_lane  = 0;
        end
        @(posedge clk_4f);
        #1;
        check("valid_8_32", {31'd0, bus.valid_8_32}, {31'd0, exp_strobe});
        check("err_partial", {31'd0, bus.err_partial}, {31'd0, exp_err});
        if (bus.valid_8_32 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", bus.data_8_32, last_word);
            end else begin
                word = exp_q.pop_front();
                check("data_8_32", bus.data_8_32, word);
                last_word = word;
            end
        end else begin
            check("data_hold", bus.data_8_32, last_word);
        end
        check("word_cnt", {16'd0, bus.word_cnt}, {16'd0, m_cnt});
    endtask

    task automatic send_word(input logic [31:0] w);
        step(w[31:24], 1'b1);
        step(w[23:16], 1'b1);
        step(w[15:8],  1'b1);
        step(w[7:0],   1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data"},  bus.data_8_32, 32'h0);
        check({tag, "_valid"}, {31'd0, bus.valid_8_32}, 32'h0);
        check({tag, "_err"},   {31'd0, bus.err_partial}, 32'h0);
        check({tag, "_cnt"},   {16'd0, bus.word_cnt}, 32'h0);
    endtask

    initial begin
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk_4f);
        #1;
        check_reset_state("reset");
        @(negedge clk_4f);
        reset = 1'b1;

        // Continuous stream: two words, strobes on bytes 44 and 88.
        step(8'h11, 1'b1); step(8'h22, 1'b1); step(8'h33, 1'b1); step(8'h44, 1'b1);
        step(8'h55, 1'b1); step(8'h66, 1'b1); step(8'h77, 1'b1); step(8'h88, 1'b1);
        step(8'h00, 1'b0);   // idle at lane 0: no error, data held

        // Gap after two bytes, then a clean word.
        step(8'hAA, 1'b1); step(8'hBB, 1'b1);
        step(8'h00, 1'b0);
        send_word(32'h01020304);

        // Gap after three bytes (lane 3 boundary), single-cycle gap after one.
        step(8'h01, 1'b1); step(8'h02, 1'b1); step(8'h03, 1'b1);
        step(8'h00, 1'b0);
        step(8'h09, 1'b1);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Async reset mid-word: outputs clear before the next edge.
        step(8'h11, 1'b1); step(8'h22, 1'b1);
        #2;
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        check_reset_state("async_reset");
        m_lane    = 0;
        m_cnt     = '0;
        last_word = '0;
        exp_q.delete();
        @(negedge clk_4f);
        reset = 1'b1;
        send_word(32'hDEADBEEF);

        // Serializer loopback: CAFEF00D held valid, bytes back to back.
        for (int n = 0; n < 3; n++) send_word(32'hCAFEF00D);
        step(8'h00, 1'b0);

        // Counter wrap: preload FFFF through the next-count path.
        @(negedge clk_4f);
        bus.valid_in = 1'b0;
        force dut.cnt_d = 16'hFFFF;
        @(posedge clk_4f);
        #1;
        release dut.cnt_d;
        m_cnt = 16'hFFFF;
        check("preload_cnt", {16'd0, bus.word_cnt}, 32'h0000FFFF);
        send_word(32'h12345678);   // word_cnt wraps to 0
        send_word(32'h9ABCDEF0);

        // Comma handling (realigns only with the optional feature).
        step(8'h00, 1'b0);
        step(8'h11, 1'b1); step(8'h22, 1'b1); step(8'hBC, 1'b1);
        step(8'h33, 1'b1); step(8'h44, 1'b1); step(8'h55, 1'b1);
        step(8'h00, 1'b0);
        // Comma in lane 0 is an ordinary byte either way.
        send_word(32'hBC010203);
        step(8'h00, 1'b0);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m8_32.md
Name: m8_32

Overview:
- Byte-to-word gatherer for the PCIe PHY receive path; the inverse of the 32-to-8 byte serializer.
- Accepts one byte per clk_4f cycle while valid is high and packs every four bytes MSB-first into a 32-bit word.
- Presents each completed word with a one-cycle strobe toward the unstriping/upper layer.
- Lane phase restarts whenever input valid drops, matching the serializer, whose selector returns to byte 0 when its valid is low.

Parameters:
- COM_SYMBOL, 8'hBC, K28.5 comma byte used for realignment (only with ALIGN_COM_EN).

Ports:
- clk_4f  input  1  byte-rate clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  8  received byte.
- valid_in  input  1  data_in is valid this cycle.
- data_8_32  output  32  assembled word; first byte in [31:24], last byte in [7:0].
- valid_8_32  output  1  one-cycle strobe: data_8_32 holds a new complete word.
- err_partial  output  1  one-cycle strobe: word aborted with 1-3 bytes collected.
- word_cnt  output  16  number of complete words emitted since reset; wraps at 16'hFFFF->0.

Behaviour:
- Reset (reset==0, asynchronous, immediate):
  - data_8_32=0, valid_8_32=0, err_partial=0, word_cnt=0.
  - Internal lane counter lane=0; shift register acc=0.
- State machine, lane counter 0..3: LANE0 (expect [31:24]), LANE1 ([23:16]), LANE2 ([15:8]), LANE3 ([7:0]).
- Each posedge with valid_in==1:
  - Write data_in into acc at the slot for the current lane.
  - Advance lane: 3 wraps to 0.
- On the posedge that accepts the LANE3 byte:
  - data_8_32 <= {acc[31:8], data_in}.
  - valid_8_32 <= 1 for exactly that cycle.
  - word_cnt <= word_cnt+1.
- Latency: 4th byte presented before edge k, so the word is visible after edge k. A back-to-back stream yields one strobe every 4 cycles.
- data_8_32 holds the last word until the next complete word or reset. It is never cleared by valid_in low.
- valid_8_32 and err_partial default to 0 on every edge not listed above.
- Posedge with valid_in==0:
  - lane <= 0 and acc <= 0.
  - If lane was 1, 2 or 3 before the edge: err_partial <= 1 for one cycle. No word is emitted and word_cnt is unchanged.
  - If lane was 0: no error.
- A valid_in gap of any length, including a single cycle, restarts assembly at LANE0 on the next valid byte.
- Reset asserted mid-word: partial bytes are discarded and no err_partial is raised. After reset release, the first valid byte is LANE0.
- word_cnt wrap: 16'hFFFF + 1 = 16'h0000, with no flag.

Optional Feature:
- Macro: M8_32_ALIGN_COM_EN.
- Defined: a valid byte equal to COM_SYMBOL accepted in LANE1..LANE3 is a realignment.
  - Discard acc and raise err_partial for one cycle.
  - Load the comma into [31:24] and set lane <= 1.
  - A comma in LANE0 is handled as a normal byte.
- Not defined: COM_SYMBOL has no special meaning and is packed like any other byte.

Test Plan:
- Reset then stream 8'h11,22,33,44,55,66,77,88 continuous -> valid_8_32 strobes on the cycle of 8'h44 with 32'h11223344, then 32'h55667788 four cycles later. word_cnt=2. err_partial never asserted.
- Bytes AA,BB, then one cycle valid_in=0, then 01,02,03,04 -> err_partial one-cycle pulse at the gap. Next word is 32'h01020304. word_cnt +1 only.
- Stream 11,22 then reset low asynchronously mid-cycle -> all outputs 0 immediately. After release, bytes DE,AD,BE,EF -> 32'hDEADBEEF, no err_partial.
- Force word_cnt to 16'hFFFF (emit 65535 words or preload) then one more word -> word_cnt=0. data_8_32 still updates correctly.
- Serializer loopback (32'hCAFEF00D held with valid) feeding m8_32 -> data_8_32 == 32'hCAFEF00D every 4 cycles.
- With M8_32_ALIGN_COM_EN: bytes 11,22,BC,33,44,55 -> err_partial at BC, then word 32'hBC334455. Without the macro, the same stream gives word 32'h1122BC33 and no error.
